// File: rtl/crypt_sequencer.sv
// -----------------------------------------------------------------------------
// crypt_sequencer
//
// Multi-cycle sequencer for the crypt instructions (R-type, funct 0x30 encrypt,
// funct 0x31 decrypt) in the single-cycle MIPS core. While a crypt instruction
// sits at PC the core is held with `stall`. The operands are handed to the
// external crypt engine over a start/ready handshake. The sequencer then waits
// a bounded time for the engine's done pulse. The result is presented to the
// RegWriteSrc = 2'b11 writeback path in the single release cycle (WB).
//
// Parameters
//   TIMEOUT_CYCLES : max WAIT cycles before a forced completion (2..65535)
//
// Ports
//   clk          in   core clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   opcode       in   [5:0]  opcode of instruction at PC
//   funct        in   [5:0]  funct field of the same instruction
//   rs_val       in   [31:0] GPRF read port 1 (data)
//   rt_val       in   [31:0] GPRF read port 2 (key)
//   eng_ready    in   engine accepts request while eng_start is high
//   eng_done     in   one-cycle pulse, eng_result valid
//   eng_result   in   [31:0] engine result
//   stall        out  freeze PC, suppress GPRF/memory writes
//   eng_start    out  request valid
//   eng_op       out  0 = encrypt, 1 = decrypt
//   eng_data     out  [31:0] latched rs_val
//   eng_key      out  [31:0] latched rt_val
//   crypt_valid  out  result is written back this cycle
//   crypt_result out  [31:0] result to the writeback mux
//   err_timeout  out  sticky wait-timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module crypt_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        eng_ready,
    input  logic        eng_done,
    input  logic [31:0] eng_result,
    output logic        stall,
    output logic        eng_start,
    output logic        eng_op,
    output logic [31:0] eng_data,
    output logic [31:0] eng_key,
    output logic        crypt_valid,
    output logic [31:0] crypt_result,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    // Last legal counter value in WAIT; reaching it without eng_done forces WB.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [15:0] wait_cnt_q;
    logic        eng_start_q;
    logic        eng_op_q;
    logic [31:0] eng_data_q;
    logic [31:0] eng_key_q;
    logic        crypt_valid_q;
    logic [31:0] crypt_result_q;
    logic        err_timeout_q;

    logic        is_crypt;

    assign is_crypt = (opcode == 6'h00) && ((funct == 6'h30) || (funct == 6'h31));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            wait_cnt_q     <= 16'd0;
            eng_start_q    <= 1'b0;
            eng_op_q       <= 1'b0;
            eng_data_q     <= 32'd0;
            eng_key_q      <= 32'd0;
            crypt_valid_q  <= 1'b0;
            crypt_result_q <= 32'd0;
            err_timeout_q  <= 1'b0;
        end else begin
            // crypt_valid is a one-cycle pulse that coincides with the WB state.
            crypt_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (is_crypt) begin
                        eng_data_q  <= rs_val;
                        eng_key_q   <= rt_val;
                        eng_op_q    <= funct[0];
                        eng_start_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // eng_done is deliberately ignored until the request is accepted.
                    if (eng_ready) begin
                        eng_start_q <= 1'b0;
                        wait_cnt_q  <= 16'd0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A done pulse on the final wait cycle takes priority over the timeout.
                    if (eng_done) begin
                        crypt_result_q <= eng_result;
                        crypt_valid_q  <= 1'b1;
                        state_q        <= ST_WB;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        crypt_result_q <= 32'd0;
                        err_timeout_q  <= 1'b1;
                        crypt_valid_q  <= 1'b1;
                        state_q        <= ST_WB;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
                end
                ST_WB: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall must cover the detection cycle itself, so the IDLE term is combinational.
    // It drops in WB, letting the core commit the writeback and PC+4.
    assign stall = ((state_q == ST_IDLE) && is_crypt)
                 || (state_q == ST_ISSUE)
                 || (state_q == ST_WAIT);

    assign eng_start    = eng_start_q;
    assign eng_op       = eng_op_q;
    assign eng_data     = eng_data_q;
    assign eng_key      = eng_key_q;
    assign crypt_valid  = crypt_valid_q;
    assign crypt_result = crypt_result_q;
    assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_crypt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_crypt_sequencer
//
// Self-checking bench for crypt_sequencer (TIMEOUT_CYCLES = 4). Inputs change
// 1 ns after the rising edge and outputs are sampled on the falling edge.
// Expected writeback results are queued when the engine response (or its
// absence) is driven and are popped when crypt_valid is observed.
// -----------------------------------------------------------------------------
module tb_crypt_sequencer;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        eng_ready;
    logic        eng_done;
    logic [31:0] eng_result;
    logic        stall;
    logic        eng_start;
    logic        eng_op;
    logic [31:0] eng_data;
    logic [31:0] eng_key;
    logic        crypt_valid;
    logic [31:0] crypt_result;
    logic        err_timeout;

    typedef struct packed {
        logic [31:0] result;
        logic        timeout;
    } exp_t;

    exp_t sb_q[$];
    exp_t exp_e;

    int checks;
    int errors;
    int vld_count;
    int vld_before;

    crypt_sequencer #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .funct       (funct),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .eng_ready   (eng_ready),
        .eng_done    (eng_done),
        .eng_result  (eng_result),
        .stall       (stall),
        .eng_start   (eng_start),
        .eng_op      (eng_op),
        .eng_data    (eng_data),
        .eng_key     (eng_key),
        .crypt_valid (crypt_valid),
        .crypt_result(crypt_result),
        .err_timeout (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts every writeback pulse, including any that should not happen.
    always @(negedge clk) begin
        if (crypt_valid === 1'b1) vld_count++;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst_n      = 1'b0;
        set_instr(6'h00, 6'h30);
        rs_val     = 32'h1111_1111;
        rt_val     = 32'h2222_2222;
        eng_ready  = 1'b0;
        eng_done   = 1'b0;
        eng_result = 32'h0;
        #2;
        checks++;
        if ({eng_start, crypt_valid, err_timeout, eng_op, eng_data, eng_key, crypt_result} !== 100'd0) begin
            errors++;
            $display("FAIL reset_outputs: got start=%b vld=%b to=%b op=%b data=%h key=%h res=%h, required all 0",
                     eng_start, crypt_valid, err_timeout, eng_op, eng_data, eng_key, crypt_result);
        end
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall_crypt: got %b required 1", stall);
        end
        set_instr(6'h00, 6'h00);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall_nop: got %b required 0", stall);
        end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({stall, eng_start, crypt_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release: got stall/start/vld=%b required 000", {stall, eng_start, crypt_valid});
        end
        next_cycle();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_encrypt();
        set_instr(6'h00, 6'h30);
        rs_val    = 32'h1234_5678;
        rt_val    = 32'hCAFE_BABE;
        eng_ready = 1'b1;
        eng_done  = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall, eng_start, crypt_valid} !== 3'b100) begin
            errors++;
            $display("FAIL enc_c0: got stall/start/vld=%b required 100", {stall, eng_start, crypt_valid});
        end
        next_cycle();
        // Operands must already be latched; changing the GPRF reads must not matter.
        rs_val = 32'hFFFF_0000;
        rt_val = 32'h0000_FFFF;
        @(negedge clk);
        checks++;
        if ({stall, eng_start, eng_op, crypt_valid} !== 4'b1100) begin
            errors++;
            $display("FAIL enc_c1_ctrl: got stall/start/op/vld=%b required 1100", {stall, eng_start, eng_op, crypt_valid});
        end
        checks++;
        if ({eng_data, eng_key} !== {32'h1234_5678, 32'hCAFE_BABE}) begin
            errors++;
            $display("FAIL enc_c1_operands: got data=%h key=%h required 12345678 cafebabe", eng_data, eng_key);
        end
        next_cycle();
        eng_done   = 1'b1;
        eng_result = 32'hDEAD_BEEF;
        sb_q.push_back('{result: 32'hDEAD_BEEF, timeout: 1'b0});
        @(negedge clk);
        checks++;
        if ({stall, eng_start, crypt_valid} !== 3'b100) begin
            errors++;
            $display("FAIL enc_c2: got stall/start/vld=%b required 100", {stall, eng_start, crypt_valid});
        end
        next_cycle();
        eng_done   = 1'b0;
        eng_result = 32'h5555_AAAA;
        @(negedge clk);
        checks++;
        if ({stall, crypt_valid} !== 2'b01) begin
            errors++;
            $display("FAIL enc_c3_wb: got stall/vld=%b required 01", {stall, crypt_valid});
        end
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL enc_sb: got writeback with empty queue, required queued result");
        end else begin
            exp_e = sb_q.pop_front();
            $display("txn encrypt: result=%h timeout=%b", crypt_result, err_timeout);
            if ({crypt_result, err_timeout} !== {exp_e.result, exp_e.timeout}) begin
                errors++;
                $display("FAIL enc_result: got %h/%b required %h/%b", crypt_result, err_timeout, exp_e.result, exp_e.timeout);
            end
        end
        next_cycle();
        set_instr(6'h00, 6'h20);
        @(negedge clk);
        checks++;
        if ({stall, eng_start, crypt_valid} !== 3'b000) begin
            errors++;
            $display("FAIL enc_c4_idle: got stall/start/vld=%b required 000", {stall, eng_start, crypt_valid});
        end
        next_cycle();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_decrypt();
        set_instr(6'h00, 6'h31);
        rs_val    = 32'hA5A5_5A5A;
        rt_val    = 32'h0F0F_F0F0;
        eng_ready = 1'b0;
        eng_done  = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall, eng_start} !== 2'b10) begin
            errors++;
            $display("FAIL dec_c0: got stall/start=%b required 10", {stall, eng_start});
        end
        for (int i = 1; i <= 6; i++) begin
            next_cycle();
            eng_ready = (i == 6);
            // A stray done before acceptance must be ignored.
            eng_done  = (i == 3);
            @(negedge clk);
            checks++;
            if ({stall, eng_start, eng_op, crypt_valid} !== 4'b1110) begin
                errors++;
                $display("FAIL dec_issue_%0d: got stall/start/op/vld=%b required 1110", i, {stall, eng_start, eng_op, crypt_valid});
            end
        end
        next_cycle();
        eng_ready = 1'b0;
        eng_done  = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall, eng_start, crypt_valid} !== 3'b100) begin
            errors++;
            $display("FAIL dec_wait0: got stall/start/vld=%b required 100", {stall, eng_start, crypt_valid});
        end
        next_cycle();
        eng_done   = 1'b1;
        eng_result = 32'h0BAD_F00D;
        sb_q.push_back('{result: 32'h0BAD_F00D, timeout: 1'b0});
        @(negedge clk);
        checks++;
        if ({stall, eng_start, crypt_valid} !== 3'b100) begin
            errors++;
            $display("FAIL dec_wait1: got stall/start/vld=%b required 100", {stall, eng_start, crypt_valid});
        end
        next_cycle();
        eng_done = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall, crypt_valid} !== 2'b01) begin
            errors++;
            $display("FAIL dec_wb: got stall/vld=%b required 01", {stall, crypt_valid});
        end
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL dec_sb: got writeback with empty queue, required queued result");
        end else begin
            exp_e = sb_q.pop_front();
            $display("txn decrypt: result=%h timeout=%b", crypt_result, err_timeout);
            if ({crypt_result, err_timeout} !== {exp_e.result, exp_e.timeout}) begin
                errors++;
                $display("FAIL dec_result: got %h/%b required %h/%b", crypt_result, err_timeout, exp_e.result, exp_e.timeout);
            end
        end
        next_cycle();
        set_instr(6'h00, 6'h00);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_done_on_timeout();
        set_instr(6'h00, 6'h30);
        eng_ready = 1'b1;
        eng_done  = 1'b0;
        next_cycle();                       // ISSUE
        for (int w = 0; w < 4; w++) begin
            next_cycle();                   // WAIT cycle w
            eng_ready = 1'b0;
            if (w == 3) begin
                eng_done   = 1'b1;
                eng_result = 32'h600D_CAFE;
                sb_q.push_back('{result: 32'h600D_CAFE, timeout: 1'b0});
            end
            @(negedge clk);
            checks++;
            if ({stall, eng_start, crypt_valid} !== 3'b100) begin
                errors++;
                $display("FAIL dto_wait_%0d: got stall/start/vld=%b required 100", w, {stall, eng_start, crypt_valid});
            end
        end
        next_cycle();
        eng_done = 1'b0;
        @(negedge clk);
        checks++;
        if (sb_q.size() == 0 || crypt_valid !== 1'b1) begin
            errors++;
            $display("FAIL dto_wb: got vld=%b queue=%0d required vld=1 with queued result", crypt_valid, sb_q.size());
        end else begin
            exp_e = sb_q.pop_front();
            $display("txn done_on_timeout: result=%h timeout=%b", crypt_result, err_timeout);
            if ({crypt_result, err_timeout} !== {exp_e.result, exp_e.timeout}) begin
                errors++;
                $display("FAIL dto_result: got %h/%b required %h/%b", crypt_result, err_timeout, exp_e.result, exp_e.timeout);
            end
        end
        next_cycle();
        set_instr(6'h00, 6'h00);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_timeout();
        set_instr(6'h00, 6'h31);
        eng_ready = 1'b1;
        eng_done  = 1'b0;
        sb_q.push_back('{result: 32'h0, timeout: 1'b1});
        next_cycle();                       // ISSUE
        for (int w = 0; w < 4; w++) begin
            next_cycle();                   // WAIT cycle w
            eng_ready = 1'b0;
            @(negedge clk);
            checks++;
            if ({stall, crypt_valid, err_timeout} !== 3'b100) begin
                errors++;
                $display("FAIL to_wait_%0d: got stall/vld/to=%b required 100", w, {stall, crypt_valid, err_timeout});
            end
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (sb_q.size() == 0 || crypt_valid !== 1'b1) begin
            errors++;
            $display("FAIL to_wb: got vld=%b queue=%0d required vld=1 with queued result", crypt_valid, sb_q.size());
        end else begin
            exp_e = sb_q.pop_front();
            $display("txn timeout: result=%h timeout=%b", crypt_result, err_timeout);
            if ({crypt_result, err_timeout} !== {exp_e.result, exp_e.timeout}) begin
                errors++;
                $display("FAIL to_result: got %h/%b required %h/%b", crypt_result, err_timeout, exp_e.result, exp_e.timeout);
            end
        end
        next_cycle();
        set_instr(6'h00, 6'h00);
        repeat (10) next_cycle();
        @(negedge clk);
        checks++;
        if ({err_timeout, stall, crypt_valid} !== 3'b100) begin
            errors++;
            $display("FAIL to_sticky: got to/stall/vld=%b required 100", {err_timeout, stall, crypt_valid});
        end
        next_cycle();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_abort_reset();
        set_instr(6'h00, 6'h31);
        rs_val    = 32'h7777_8888;
        rt_val    = 32'h9999_AAAA;
        eng_ready = 1'b1;
        eng_done  = 1'b0;
        next_cycle();                       // ISSUE
        next_cycle();                       // WAIT
        eng_ready  = 1'b0;
        vld_before = vld_count;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({eng_start, crypt_valid, err_timeout, eng_op, eng_data, eng_key, crypt_result} !== 100'd0) begin
            errors++;
            $display("FAIL abort_outputs: got start=%b vld=%b to=%b op=%b data=%h key=%h res=%h, required all 0",
                     eng_start, crypt_valid, err_timeout, eng_op, eng_data, eng_key, crypt_result);
        end
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL abort_stall_idle: got %b required 1 (IDLE with crypt at PC)", stall);
        end
        set_instr(6'h00, 6'h20);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL abort_stall_nop: got %b required 0", stall);
        end
        next_cycle();
        rst_n      = 1'b1;
        eng_done   = 1'b1;                  // late engine response must be ignored
        eng_result = 32'h1234_4321;
        next_cycle();
        eng_done = 1'b0;
        repeat (5) next_cycle();
        @(negedge clk);
        checks++;
        if (vld_count !== vld_before) begin
            errors++;
            $display("FAIL abort_no_wb: got %0d writeback pulses required 0", vld_count - vld_before);
        end
        next_cycle();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [5:0]  nc_op [3];
        logic [5:0]  nc_fn [3];
        logic [31:0] b2b_res [2];
        logic [5:0]  b2b_fn [2];
        nc_op = '{6'h00, 6'h23, 6'h00};
        nc_fn = '{6'h20, 6'h30, 6'h08};     // add, lw (funct bits look like crypt), jr
        b2b_res = '{32'hAAAA_0001, 32'hBBBB_0002};
        b2b_fn  = '{6'h30, 6'h31};
        eng_ready = 1'b1;
        eng_done  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_instr(nc_op[k], nc_fn[k]);
            @(negedge clk);
            checks++;
            if ({stall, eng_start} !== 2'b00) begin
                errors++;
                $display("FAIL b2b_noncrypt_%0d: got stall/start=%b required 00", k, {stall, eng_start});
            end
            next_cycle();
        end
        vld_before = vld_count;
        for (int k = 0; k < 2; k++) begin
            set_instr(6'h00, b2b_fn[k]);
            rs_val = 32'h1000_0000 + k;
            @(negedge clk);
            checks++;
            if ({stall, eng_start, crypt_valid} !== 3'b100) begin
                errors++;
                $display("FAIL b2b_detect_%0d: got stall/start/vld=%b required 100", k, {stall, eng_start, crypt_valid});
            end
            next_cycle();                   // ISSUE
            @(negedge clk);
            checks++;
            if ({eng_start, eng_op, eng_data} !== {1'b1, b2b_fn[k][0], 32'h1000_0000 + k}) begin
                errors++;
                $display("FAIL b2b_issue_%0d: got start=%b op=%b data=%h", k, eng_start, eng_op, eng_data);
            end
            next_cycle();                   // WAIT
            eng_done   = 1'b1;
            eng_result = b2b_res[k];
            sb_q.push_back('{result: b2b_res[k], timeout: 1'b0});
            next_cycle();                   // WB
            eng_done = 1'b0;
            @(negedge clk);
            checks++;
            if (sb_q.size() == 0 || crypt_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_wb_%0d: got vld=%b queue=%0d required vld=1 with queued result", k, crypt_valid, sb_q.size());
            end else begin
                exp_e = sb_q.pop_front();
                $display("txn back_to_back_%0d: result=%h timeout=%b", k, crypt_result, err_timeout);
                if ({crypt_result, err_timeout} !== {exp_e.result, exp_e.timeout}) begin
                    errors++;
                    $display("FAIL b2b_result_%0d: got %h/%b required %h/%b", k, crypt_result, err_timeout, exp_e.result, exp_e.timeout);
                end
            end
            next_cycle();
        end
        set_instr(6'h00, 6'h00);
        repeat (3) next_cycle();
        @(negedge clk);
        checks++;
        if (vld_count - vld_before !== 2) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d writeback pulses required 2", vld_count - vld_before);
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        checks    = 0;
        errors    = 0;
        vld_count = 0;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_done_on_timeout();
        test_timeout();
        test_abort_reset();
        test_back_to_back();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d unconsumed results required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
